multi_channel_controller: RTL and testbench

MULTI_CHANNEL_CONTROLLER -- requirements
Module: multi_channel_controller

---
 rtl/multi_channel_controller.sv | 187 ++++++++++++++++++
 tb/tb_multi_channel_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_controller.sv
// Time-multiplexed voice sequencer: each frame tick walks every channel through a note or envelope pass.
// Optional macro WAIT_TIMEOUT_EN: aborts stalled pattern/pitch waits after TIMEOUT_CYCLES cycles.
module multi_channel_controller #(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned CH_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tick_stb,
  input  logic            i_note_stb,
  output logic [CH_W-1:0] o_channel,
  output logic            o_pattern_enable,
  input  logic            i_pattern_valid,
  output logic            o_pitch_lookup_enable,
  input  logic            i_pitch_lookup_valid,
  output logic            o_duration_enable,
  output logic            o_duration_load,
  input  logic            i_duration_running,
  output logic            o_envelope_enable,
  output logic            o_envelope_load,
  output logic            o_valid,
  output logic            o_frame_done,
  output logic            o_busy,
  output logic            o_overrun,
  output logic            o_timeout
);

  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_CONTINUE,
    S_ENV,
    S_EN_PAT,
    S_WAIT_PAT,
    S_EN_PITCH,
    S_WAIT_PITCH,
    S_LOAD,
    S_VALID
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            note_pass_q, note_pass_d;
  logic            overrun_q;
  logic            wait_done_c;
  logic            to_abort_c;

  // A handshake only counts while we are parked in the matching wait state
  assign wait_done_c = ((state_q == S_WAIT_PAT)   && i_pattern_valid) ||
                       ((state_q == S_WAIT_PITCH) && i_pitch_lookup_valid);

`ifdef WAIT_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           in_wait_c;
  logic           timeout_q;

  // Counts consecutive stalled wait cycles; cleared whenever a wait is left
  always_comb begin
    in_wait_c  = (state_q == S_WAIT_PAT) || (state_q == S_WAIT_PITCH);
    to_abort_c = in_wait_c && !wait_done_c && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
    to_cnt_d   = '0;
    if (in_wait_c && !wait_done_c && !to_abort_c) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= to_abort_c;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg_c;

  assign to_abort_c           = 1'b0;
  assign o_timeout            = 1'b0;
  assign unused_timeout_cfg_c = ^32'(TIMEOUT_CYCLES);
`endif

  // State, channel index, pass type and overrun flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      note_pass_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      note_pass_q <= note_pass_d;
      overrun_q   <= i_tick_stb && (state_q != S_IDLE);
    end
  end

  // Next-state and channel sequencing
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    note_pass_d = note_pass_q;
    case (state_q)
      S_IDLE: begin
        if (i_tick_stb) begin
          ch_d        = '0;
          note_pass_d = i_note_stb;
          state_d     = i_note_stb ? S_CHECK : S_ENV;
        end
      end
      S_CHECK:    state_d = i_duration_running ? S_CONTINUE : S_EN_PAT;
      S_CONTINUE: state_d = S_VALID;
      S_ENV:      state_d = S_VALID;
      S_EN_PAT:   state_d = S_WAIT_PAT;
      S_WAIT_PAT: begin
        if (i_pattern_valid) begin
          state_d = S_EN_PITCH;
        end else if (to_abort_c) begin
          state_d = S_VALID;
        end
      end
      S_EN_PITCH: state_d = S_WAIT_PITCH;
      S_WAIT_PITCH: begin
        if (i_pitch_lookup_valid) begin
          state_d = S_LOAD;
        end else if (to_abort_c) begin
          state_d = S_VALID;
        end
      end
      S_LOAD:     state_d = S_VALID;
      S_VALID: begin
        if (ch_q == LastCh) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = note_pass_q ? S_CHECK : S_ENV;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore strobes decoded from the registered state
  always_comb begin
    o_pattern_enable      = 1'b0;
    o_pitch_lookup_enable = 1'b0;
    o_duration_enable     = 1'b0;
    o_duration_load       = 1'b0;
    o_envelope_enable     = 1'b0;
    o_envelope_load       = 1'b0;
    o_valid               = 1'b0;
    o_frame_done          = 1'b0;
    o_busy                = (state_q != S_IDLE);
    case (state_q)
      S_CONTINUE: begin
        o_duration_enable = 1'b1;
        o_envelope_enable = 1'b1;
      end
      S_ENV:      o_envelope_enable     = 1'b1;
      S_EN_PAT:   o_pattern_enable      = 1'b1;
      S_EN_PITCH: o_pitch_lookup_enable = 1'b1;
      S_LOAD: begin
        o_duration_enable = 1'b1;
        o_duration_load   = 1'b1;
        o_envelope_enable = 1'b1;
        o_envelope_load   = 1'b1;
      end
      S_VALID: begin
        o_valid      = 1'b1;
        o_frame_done = (ch_q == LastCh);
      end
      default: ;
    endcase
  end

  assign o_channel = ch_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_multi_channel_controller.sv
// Scoreboard bench for multi_channel_controller: expected per-channel valids are queued at each tick.
module tb_multi_channel_controller;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;
  localparam int unsigned TMO = 8;

  localparam int C_VALID = 0, C_PAT = 1, C_PITCH = 2, C_DEN = 3, C_DLD = 4,
                 C_EEN = 5, C_ELD = 6, C_LALL = 7, C_OVR = 8, C_FRM = 9;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_tick_stb = 1'b0;
  logic           i_note_stb = 1'b0;
  logic           i_pattern_valid = 1'b0;
  logic           i_pitch_lookup_valid = 1'b0;
  logic           i_duration_running;
  logic [CHW-1:0] o_channel;
  logic o_pattern_enable, o_pitch_lookup_enable, o_duration_enable, o_duration_load;
  logic o_envelope_enable, o_envelope_load, o_valid, o_frame_done, o_busy, o_overrun, o_timeout;

  logic [NCH-1:0] run_mask = '0;
  logic pat_en = 1'b1, pitch_en = 1'b1;
  int   pat_dly = 2, pitch_dly = 2, pitch_block_ch = -1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           last;
    logic           tmo;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   frame_cyc = 0;
  int   cnt [10] = '{default: 0};
  int   snap [10];

  multi_channel_controller #(
    .NUM_CHANNELS(NCH), .CH_W(CHW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick_stb(i_tick_stb), .i_note_stb(i_note_stb),
    .o_channel(o_channel),
    .o_pattern_enable(o_pattern_enable), .i_pattern_valid(i_pattern_valid),
    .o_pitch_lookup_enable(o_pitch_lookup_enable), .i_pitch_lookup_valid(i_pitch_lookup_valid),
    .o_duration_enable(o_duration_enable), .o_duration_load(o_duration_load),
    .i_duration_running(i_duration_running),
    .o_envelope_enable(o_envelope_enable), .o_envelope_load(o_envelope_load),
    .o_valid(o_valid), .o_frame_done(o_frame_done), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  assign i_duration_running = run_mask[o_channel];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_pattern_enable, o_pitch_lookup_enable, o_duration_enable, o_duration_load,
                o_envelope_enable, o_envelope_load, o_valid, o_frame_done, o_busy,
                o_overrun, o_timeout, o_channel});
  endfunction

  task automatic check_delta(input string tag, input int idx, input int exp);
    check(tag, 32'(cnt[idx] - snap[idx]), 32'(exp));
  endtask

  // Output monitor: counts strobes and scores each o_valid against the queue
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_pattern_enable)      cnt[C_PAT]   <= cnt[C_PAT] + 1;
      if (o_pitch_lookup_enable) cnt[C_PITCH] <= cnt[C_PITCH] + 1;
      if (o_duration_enable)     cnt[C_DEN]   <= cnt[C_DEN] + 1;
      if (o_duration_load)       cnt[C_DLD]   <= cnt[C_DLD] + 1;
      if (o_envelope_enable)     cnt[C_EEN]   <= cnt[C_EEN] + 1;
      if (o_envelope_load)       cnt[C_ELD]   <= cnt[C_ELD] + 1;
      if (o_overrun)             cnt[C_OVR]   <= cnt[C_OVR] + 1;
      if (o_duration_enable && o_duration_load && o_envelope_enable && o_envelope_load)
        cnt[C_LALL] <= cnt[C_LALL] + 1;
      if (o_frame_done) begin
        cnt[C_FRM] <= cnt[C_FRM] + 1;
        frame_cyc  <= cyc;
      end
      if (o_valid) begin
        cnt[C_VALID] <= cnt[C_VALID] + 1;
        if (exp_q.size() == 0) begin
          check("valid_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          check("valid_channel", 32'(o_channel), 32'(exp_q[0].ch));
          check("valid_frame_done", 32'(o_frame_done), 32'(exp_q[0].last));
          check("valid_timeout", 32'(o_timeout), 32'(exp_q[0].tmo));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Pattern fetch responder
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_pattern_enable && pat_en) begin
        repeat (pat_dly) @(negedge i_clk);
        i_pattern_valid = 1'b1;
        @(negedge i_clk);
        i_pattern_valid = 1'b0;
      end
    end
  end

  // Pitch lookup responder; can be told to stall one channel
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_pitch_lookup_enable && pitch_en && (int'(o_channel) != pitch_block_ch)) begin
        repeat (pitch_dly) @(negedge i_clk);
        i_pitch_lookup_valid = 1'b1;
        @(negedge i_clk);
        i_pitch_lookup_valid = 1'b0;
      end
    end
  end

  task automatic push_frame(input logic tmo);
    exp_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      e.ch   = CHW'(ch);
      e.last = (ch == NCH - 1);
      e.tmo  = tmo;
      exp_q.push_back(e);
    end
  endtask

  // One frame: tick, optional second tick while busy, bounded wait for frame_done
  task automatic run_pass(input string tag, input logic note, input logic tmo,
                          input int lat, input int ovr_at);
    int t0, f0;
    bit got;
    snap = cnt;
    @(negedge i_clk);
    push_frame(tmo);
    t0 = cyc;
    f0 = cnt[C_FRM];
    i_tick_stb = 1'b1;
    i_note_stb = note;
    @(negedge i_clk);
    i_tick_stb = 1'b0;
    i_note_stb = 1'b0;
    if (ovr_at > 0) begin
      repeat (ovr_at - 1) @(negedge i_clk);
      i_tick_stb = 1'b1;
      i_note_stb = 1'b1;
      @(negedge i_clk);
      i_tick_stb = 1'b0;
      i_note_stb = 1'b0;
      check({tag, "_overrun_pulse"}, 32'(o_overrun), 32'd1);
      @(negedge i_clk);
      check({tag, "_overrun_clear"}, 32'(o_overrun), 32'd0);
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge i_clk);
      if (cnt[C_FRM] != f0) got = 1'b1;
    end
    if (!got) check({tag, "_frame_wait"}, 32'(cnt[C_FRM] - f0), 32'd1);
    else      check({tag, "_latency"}, 32'(frame_cyc - t0), 32'(lat));
    @(negedge i_clk);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
    check_delta({tag, "_valids"}, C_VALID, NCH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outs", outs(), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_reset_outs", outs(), 32'd0);

    // Note pass with every channel still sounding
    run_mask = '1;
    run_pass("cont", 1'b1, 1'b0, 3 * NCH, 0);
    check_delta("cont_den", C_DEN, NCH);
    check_delta("cont_pat", C_PAT, 0);
    check_delta("cont_dld", C_DLD, 0);

    // Note pass fetching a new note on every channel
    run_mask = '0;
    pat_dly = 2;
    pitch_dly = 2;
    run_pass("newnote", 1'b1, 1'b0, 9 * NCH, 0);
    check_delta("newnote_pat", C_PAT, NCH);
    check_delta("newnote_pitch", C_PITCH, NCH);
    check_delta("newnote_loadall", C_LALL, NCH);
    check_delta("newnote_eld", C_ELD, NCH);

    // Envelope-only pass
    run_pass("env", 1'b0, 1'b0, 2 * NCH, 0);
    check_delta("env_een", C_EEN, NCH);
    check_delta("env_den", C_DEN, 0);
    check_delta("env_pat", C_PAT, 0);

    // Second tick mid-pass
    run_pass("ovr", 1'b0, 1'b0, 2 * NCH, 2);
    check_delta("ovr_count", C_OVR, 1);

    // Mixed sounding/new channels with minimum handshake latency
    run_mask = 4'b0101;
    pat_dly = 1;
    pitch_dly = 1;
    run_pass("mixed", 1'b1, 1'b0, 20, 0);
    check_delta("mixed_pat", C_PAT, 2);
    check_delta("mixed_loadall", C_LALL, 2);
    check_delta("mixed_den", C_DEN, NCH);

    // Reset while channel 2 waits on its pitch lookup
    run_mask = '0;
    pitch_block_ch = 2;
    @(negedge i_clk);
    push_frame(1'b0);
    i_tick_stb = 1'b1;
    i_note_stb = 1'b1;
    @(negedge i_clk);
    i_tick_stb = 1'b0;
    i_note_stb = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge i_clk);
      if (o_pitch_lookup_enable && (o_channel == CHW'(2))) found = 1'b1;
    end
    check("rst_reach_ch2", 32'(found), 32'd1);
    @(negedge i_clk);
    check("rst_waiting_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_midpass_outs", outs(), 32'd0);
    i_rst = 1'b0;
    check("rst_pending_valids", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    repeat (3) @(negedge i_clk);
    check("rst_stays_idle", outs(), 32'd0);
    pitch_block_ch = -1;
    run_mask = '1;
    run_pass("restart", 1'b1, 1'b0, 3 * NCH, 0);

`ifdef WAIT_TIMEOUT_EN
    // Pattern fetch never answers: every channel aborts after TMO wait cycles
    run_mask = '0;
    pat_en = 1'b0;
    run_pass("timeout", 1'b1, 1'b1, (3 + TMO) * NCH, 0);
    check_delta("timeout_pat", C_PAT, NCH);
    check_delta("timeout_pitch", C_PITCH, 0);
    check_delta("timeout_dld", C_DLD, 0);
    check_delta("timeout_eld", C_ELD, 0);
    pat_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
